// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - I2C bit-command codes and one-hot byte-sequencer state encoding
package i2c_pkg;
    localparam logic [3:0] CMD_NOP   = 4'b0000;
    localparam logic [3:0] CMD_START = 4'b0001;
    localparam logic [3:0] CMD_STOP  = 4'b0010;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_READ  = 4'b1000;

    typedef enum logic [5:0] {
        ST_IDLE  = 6'b000001,
        ST_START = 6'b000010,
        ST_READ  = 6'b000100,
        ST_WRITE = 6'b001000,
        ST_ACK   = 6'b010000,
        ST_STOP  = 6'b100000
    } byte_state_e;
endpackage

// File: rtl/i2c_byte_shreg.sv
// rtl/i2c_byte_shreg.sv - 8-bit load/shift data register with 3-bit bit counter
module i2c_byte_shreg
    import i2c_pkg::*;
(
    input  logic       clk,
    input  logic       nReset,
    input  logic       load,
    input  logic       shift,
    input  logic [7:0] din,
    input  logic       rxd,
    output logic [7:0] sr,
    output logic       cnt_done
);
    logic [7:0] sr_q, sr_d;
    logic [2:0] cnt_q, cnt_d;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (load) begin
            sr_d  = din;
            cnt_d = 3'd7;
        end else if (shift) begin
            sr_d  = {sr_q[6:0], rxd};
            cnt_d = cnt_q - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            sr_q  <= 8'h00;
            cnt_q <= 3'd0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign sr       = sr_q;
    assign cnt_done = (cnt_q == 3'd0);
endmodule

// File: rtl/i2c_master_byte_seq.sv
// rtl/i2c_master_byte_seq.sv - I2C byte sequencer issuing bit commands; I2C_BYTE_TIMEOUT_EN adds a core_ack watchdog
module i2c_master_byte_seq
    import i2c_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65535
)
(
    input  logic       clk,
    input  logic       nReset,
    input  logic       start,
    input  logic       stop,
    input  logic       read,
    input  logic       write,
    input  logic       ack_in,
    input  logic [7:0] din,
    output logic       cmd_ack,
    output logic       ack_out,
    output logic [7:0] dout,
    output logic [3:0] core_cmd,
    output logic       core_txd,
    input  logic       core_ack,
    input  logic       core_rxd,
    input  logic       i2c_al
`ifdef I2C_BYTE_TIMEOUT_EN
    ,
    output logic       timeout
`endif
);
    byte_state_e state_q, state_d;
    logic [3:0]  core_cmd_q, core_cmd_d;
    logic        core_txd_q, core_txd_d;
    logic        cmd_ack_q, cmd_ack_d;
    logic        ack_out_q, ack_out_d;
    logic        ld, shift, cnt_done, go;
    logic [7:0]  sr;

`ifdef I2C_BYTE_TIMEOUT_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wd_q, wd_d;
    logic        timeout_q, timeout_d;
`endif

    // The ~cmd_ack term keeps held requests from restarting in the completion cycle.
    assign go = (start | stop | read | write) & ~cmd_ack_q;

    i2c_byte_shreg u_shreg (
        .clk      (clk),
        .nReset   (nReset),
        .load     (ld),
        .shift    (shift),
        .din      (din),
        .rxd      (core_rxd),
        .sr       (sr),
        .cnt_done (cnt_done)
    );

    always_comb begin
        state_d    = state_q;
        core_cmd_d = core_cmd_q;
        core_txd_d = core_txd_q;
        ack_out_d  = ack_out_q;
        cmd_ack_d  = 1'b0;
        ld         = 1'b0;
        shift      = 1'b0;
        if (i2c_al) begin
            state_d    = ST_IDLE;
            core_cmd_d = CMD_NOP;
            core_txd_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (go) begin
                    ld         = 1'b1;
                    core_txd_d = din[7];
                    if (start) begin
                        state_d = ST_START;  core_cmd_d = CMD_START;
                    end else if (read) begin
                        state_d = ST_READ;   core_cmd_d = CMD_READ;
                    end else if (write) begin
                        state_d = ST_WRITE;  core_cmd_d = CMD_WRITE;
                    end else begin
                        state_d = ST_STOP;   core_cmd_d = CMD_STOP;
                    end
                end
                ST_START: if (core_ack) begin
                    core_txd_d = din[7];
                    if (read) begin
                        state_d = ST_READ;   core_cmd_d = CMD_READ;
                    end else begin
                        state_d = ST_WRITE;  core_cmd_d = CMD_WRITE;
                    end
                end
                ST_WRITE, ST_READ: if (core_ack) begin
                    shift = 1'b1;
                    if (cnt_done) begin
                        state_d = ST_ACK;
                        if (state_q == ST_READ) begin
                            core_cmd_d = CMD_WRITE;  core_txd_d = ack_in;
                        end else begin
                            core_cmd_d = CMD_READ;   core_txd_d = 1'b1;
                        end
                    end else if (state_q == ST_WRITE) begin
                        // sr[6] becomes sr[7] after this shift
                        core_txd_d = sr[6];
                    end
                end
                ST_ACK: if (core_ack) begin
                    ack_out_d  = core_rxd;
                    core_txd_d = 1'b1;
                    if (stop) begin
                        state_d = ST_STOP;  core_cmd_d = CMD_STOP;
                    end else begin
                        state_d = ST_IDLE;  core_cmd_d = CMD_NOP;  cmd_ack_d = 1'b1;
                    end
                end
                ST_STOP: if (core_ack) begin
                    state_d = ST_IDLE;  core_cmd_d = CMD_NOP;  cmd_ack_d = 1'b1;
                end
                default: begin
                    state_d    = ST_IDLE;
                    core_cmd_d = CMD_NOP;
                end
            endcase
        end
`ifdef I2C_BYTE_TIMEOUT_EN
        wd_d      = 16'd0;
        timeout_d = 1'b0;
        if (!i2c_al && state_q != ST_IDLE && !core_ack) begin
            if (wd_q == WD_LAST) begin
                state_d    = ST_IDLE;
                core_cmd_d = CMD_NOP;
                timeout_d  = 1'b1;
            end else begin
                wd_d = wd_q + 16'd1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q    <= ST_IDLE;
            core_cmd_q <= CMD_NOP;
            core_txd_q <= 1'b0;
            cmd_ack_q  <= 1'b0;
            ack_out_q  <= 1'b0;
`ifdef I2C_BYTE_TIMEOUT_EN
            wd_q       <= 16'd0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            core_cmd_q <= core_cmd_d;
            core_txd_q <= core_txd_d;
            cmd_ack_q  <= cmd_ack_d;
            ack_out_q  <= ack_out_d;
`ifdef I2C_BYTE_TIMEOUT_EN
            wd_q       <= wd_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign core_cmd = core_cmd_q;
    assign core_txd = core_txd_q;
    assign cmd_ack  = cmd_ack_q;
    assign ack_out  = ack_out_q;
    assign dout     = sr;
`ifdef I2C_BYTE_TIMEOUT_EN
    assign timeout  = timeout_q;
`endif
endmodule
